// File: rtl/cache_line_fill_pkg.sv
// cache_line_fill_pkg
//   Shared cache configuration for the miss-fill engine. It holds the pixel, line, beat
//   and address widths, the derived line size and beat count, and the fill FSM state
//   encoding.
//   The packed line must be an integer number of DDR beats:
//   PIXEL_BITS*CACHE_LINE_WDTH % BEAT_WDTH == 0.
package cache_line_fill_pkg;

   localparam int PIXEL_BITS      = 8;
   localparam int CACHE_LINE_WDTH = 64;
   localparam int BEAT_WDTH       = 128;
   localparam int MEM_ADDR_WDTH   = 7;
   localparam int DDR_ADDR_WDTH   = 32;

   localparam int LINE_BITS = PIXEL_BITS * CACHE_LINE_WDTH;
   localparam int BEATS     = LINE_BITS / BEAT_WDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_WRITE = 2'd3
   } fill_state_e;

   // A counter for a single-beat line still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_fill_beat_packer.sv
// cache_fill_beat_packer
//   Counts the accepted DDR read beats and writes each beat into its slot of the
//   line register (beat 0 is least significant). It also checks r_last against
//   the beat count.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clr_i             restart the beat count (burst address accepted)
//   beat_en_i         a beat is accepted this cycle
//   beat_data_i       beat payload
//   beat_last_i       r_last marker that travels with the beat
//   line_o            assembled line (not cleared by reset)
//   line_full_o       the beat accepted this cycle completes the line
//   len_err_o         sticky: r_last did not match the final beat position
module cache_fill_beat_packer
   import cache_line_fill_pkg::*;
#(
   parameter  int BEAT_WDTH = 128,
   parameter  int BEATS     = 4,
   localparam int LINE_BITS = BEAT_WDTH * BEATS,
   localparam int CNT_W     = cnt_width(BEATS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 beat_en_i,
   input  logic [BEAT_WDTH-1:0] beat_data_i,
   input  logic                 beat_last_i,
   output logic [LINE_BITS-1:0] line_o,
   output logic                 line_full_o,
   output logic                 len_err_o
);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 len_err_q, len_err_d;
   logic [LINE_BITS-1:0] line_q;
   logic                 at_last;

   assign at_last = (cnt_q == CNT_W'(BEATS - 1));

   // The count alone ends the burst. A misplaced or missing r_last only raises the error flag.
   always_comb begin
      cnt_d     = cnt_q;
      len_err_d = len_err_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (beat_en_i) begin
         cnt_d = at_last ? '0 : cnt_q + 1'b1;
         if (beat_last_i != at_last) len_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   // Every slot of the line is overwritten before it is used, so this register has no reset.
   always_ff @(posedge clk) begin
      if (beat_en_i) line_q[cnt_q*BEAT_WDTH +: BEAT_WDTH] <= beat_data_i;
   end

   assign line_o      = line_q;
   assign line_full_o = beat_en_i & at_last;
   assign len_err_o   = len_err_q;

endmodule

// File: rtl/cache_line_fill.sv
// cache_line_fill
//   Miss-fill engine for the reference-picture cache. It takes one miss at a time
//   and issues one DDR read burst for it. It packs the returned beats into a cache
//   line and then writes that line to the data memory in a single cycle. The same
//   cycle pulses fill_done to the tag/miss controller.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   miss_valid_in/miss_ready_out   miss request handshake
//   miss_ddr_addr_in               DDR byte address of the line
//   miss_line_addr_in              destination data-memory line index
//   ar_*                           DDR read address channel (len = BEATS-1)
//   r_*                            DDR read data channel
//   w_en_out/addr_out/w_data_out   data-memory line write
//   fill_done_out/fill_line_addr_out  completion pulse and line index
//   err_out                        sticky burst-length error
// Build option:
//   CACHE_FILL_BYPASS_EN adds bypass_valid_out/bypass_data_out. These carry the
//   written line to the pixel fetch stage in the write cycle.
//
// state  | meaning
// IDLE   | ready for a miss; latch address/index on accept
// ADDR   | ar_valid held with a stable address until ar_ready
// DATA   | accept beats until BEATS have been packed
// WRITE  | one-cycle line write plus fill_done pulse
module cache_line_fill
   import cache_line_fill_pkg::*;
#(
   parameter  int PIXEL_BITS      = cache_line_fill_pkg::PIXEL_BITS,
   parameter  int CACHE_LINE_WDTH = cache_line_fill_pkg::CACHE_LINE_WDTH,
   parameter  int BEAT_WDTH       = cache_line_fill_pkg::BEAT_WDTH,
   parameter  int MEM_ADDR_WDTH   = cache_line_fill_pkg::MEM_ADDR_WDTH,
   parameter  int DDR_ADDR_WDTH   = cache_line_fill_pkg::DDR_ADDR_WDTH,
   localparam int LINE_BITS       = PIXEL_BITS * CACHE_LINE_WDTH,
   localparam int BEATS           = LINE_BITS / BEAT_WDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     miss_valid_in,
   output logic                     miss_ready_out,
   input  logic [DDR_ADDR_WDTH-1:0] miss_ddr_addr_in,
   input  logic [MEM_ADDR_WDTH-1:0] miss_line_addr_in,
   output logic                     ar_valid_out,
   input  logic                     ar_ready_in,
   output logic [DDR_ADDR_WDTH-1:0] ar_addr_out,
   output logic [7:0]               ar_len_out,
   input  logic                     r_valid_in,
   output logic                     r_ready_out,
   input  logic [BEAT_WDTH-1:0]     r_data_in,
   input  logic                     r_last_in,
   output logic                     w_en_out,
   output logic [MEM_ADDR_WDTH-1:0] addr_out,
   output logic [LINE_BITS-1:0]     w_data_out,
   output logic                     fill_done_out,
   output logic [MEM_ADDR_WDTH-1:0] fill_line_addr_out,
   output logic                     err_out
`ifdef CACHE_FILL_BYPASS_EN
   ,
   output logic                     bypass_valid_out,
   output logic [LINE_BITS-1:0]     bypass_data_out
`endif
);

   fill_state_e              state_q, state_d;
   logic [DDR_ADDR_WDTH-1:0] ddr_addr_q, ddr_addr_d;
   logic [MEM_ADDR_WDTH-1:0] line_addr_q, line_addr_d;
   logic [MEM_ADDR_WDTH-1:0] addr_q, addr_d;
   logic                     ar_hs;
   logic                     beat_en;
   logic                     line_full;
   logic                     len_err;
   logic [LINE_BITS-1:0]     line;

   assign ar_hs   = (state_q == ST_ADDR) & ar_ready_in;
   assign beat_en = (state_q == ST_DATA) & r_valid_in;

   always_comb begin
      state_d     = state_q;
      ddr_addr_d  = ddr_addr_q;
      line_addr_d = line_addr_q;
      addr_d      = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_valid_in) begin
               ddr_addr_d  = miss_ddr_addr_in;
               line_addr_d = miss_line_addr_in;
               state_d     = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ar_ready_in) state_d = ST_DATA;
         end
         ST_DATA: begin
            // addr_out moves only here, so it keeps the last written index between fills.
            if (line_full) begin
               addr_d  = line_addr_q;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ddr_addr_q  <= '0;
         line_addr_q <= '0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         ddr_addr_q  <= ddr_addr_d;
         line_addr_q <= line_addr_d;
         addr_q      <= addr_d;
      end
   end

   cache_fill_beat_packer #(
      .BEAT_WDTH (BEAT_WDTH),
      .BEATS     (BEATS)
   ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (ar_hs),
      .beat_en_i   (beat_en),
      .beat_data_i (r_data_in),
      .beat_last_i (r_last_in),
      .line_o      (line),
      .line_full_o (line_full),
      .len_err_o   (len_err)
   );

   assign miss_ready_out     = (state_q == ST_IDLE);
   assign ar_valid_out       = (state_q == ST_ADDR);
   assign ar_addr_out        = ar_valid_out ? ddr_addr_q : '0;
   assign ar_len_out         = ar_valid_out ? 8'(BEATS - 1) : 8'd0;
   assign r_ready_out        = (state_q == ST_DATA);
   // w_en pre-empts data-memory reads, so it must stay strictly one cycle wide.
   assign w_en_out           = (state_q == ST_WRITE);
   assign addr_out           = addr_q;
   assign w_data_out         = w_en_out ? line : '0;
   assign fill_done_out      = w_en_out;
   assign fill_line_addr_out = w_en_out ? line_addr_q : '0;
   assign err_out            = len_err;

`ifdef CACHE_FILL_BYPASS_EN
   assign bypass_valid_out = w_en_out;
   assign bypass_data_out  = w_data_out;
`endif

endmodule

// File: tb/tb_cache_line_fill.sv
module tb_cache_line_fill;

   localparam int DW = 32;
   localparam int LW = 7;
   localparam int BW = 128;
   localparam int NB = 4;
   localparam int LB = BW * NB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          miss_valid_in = 1'b0;
   logic          miss_ready_out;
   logic [DW-1:0] miss_ddr_addr_in = '0;
   logic [LW-1:0] miss_line_addr_in = '0;
   logic          ar_valid_out;
   logic          ar_ready_in = 1'b0;
   logic [DW-1:0] ar_addr_out;
   logic [7:0]    ar_len_out;
   logic          r_valid_in = 1'b0;
   logic          r_ready_out;
   logic [BW-1:0] r_data_in = '0;
   logic          r_last_in = 1'b0;
   logic          w_en_out;
   logic [LW-1:0] addr_out;
   logic [LB-1:0] w_data_out;
   logic          fill_done_out;
   logic [LW-1:0] fill_line_addr_out;
   logic          err_out;
`ifdef CACHE_FILL_BYPASS_EN
   logic          bypass_valid_out;
   logic [LB-1:0] bypass_data_out;
`endif

   cache_line_fill dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .miss_valid_in      (miss_valid_in),
      .miss_ready_out     (miss_ready_out),
      .miss_ddr_addr_in   (miss_ddr_addr_in),
      .miss_line_addr_in  (miss_line_addr_in),
      .ar_valid_out       (ar_valid_out),
      .ar_ready_in        (ar_ready_in),
      .ar_addr_out        (ar_addr_out),
      .ar_len_out         (ar_len_out),
      .r_valid_in         (r_valid_in),
      .r_ready_out        (r_ready_out),
      .r_data_in          (r_data_in),
      .r_last_in          (r_last_in),
      .w_en_out           (w_en_out),
      .addr_out           (addr_out),
      .w_data_out         (w_data_out),
      .fill_done_out      (fill_done_out),
      .fill_line_addr_out (fill_line_addr_out),
      .err_out            (err_out)
`ifdef CACHE_FILL_BYPASS_EN
      ,
      .bypass_valid_out   (bypass_valid_out),
      .bypass_data_out    (bypass_data_out)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // rmode: 0 = beat every cycle, 1 = r_valid toggling, 2 = random r_valid
   typedef struct {
      logic [DW-1:0] ddr;
      logic [LW-1:0] line;
      logic [LB-1:0] data;
      logic [3:0]    last_mask;
      int            ar_wait;
      int            rmode;
      bit            exp_err;
   } vec_t;

   vec_t tab[6];

   task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [LB-1:0] mk_line(input logic [31:0] seed);
      logic [LB-1:0] l;
      l = '0;
      for (int k = 0; k < NB; k++) l[k*BW +: BW] = {4{seed + 32'(k)}};
      return l;
   endfunction

   // Runs one fill from a negedge. When pending is set, the request is already on the bus.
   // When hold is set, the next request is driven as soon as this one is accepted.
   task automatic do_fill(input vec_t v, input bit pending, input bit hold, input vec_t nxt,
                          input bit exp_err);
      int  cyc;
      int  w;
      int  k;
      int  guard;
      int  unstable;
      int  rbad;
      bit  tgl;
      if (!pending) begin
         @(negedge clk);
         miss_valid_in     = 1'b1;
         miss_ddr_addr_in  = v.ddr;
         miss_line_addr_in = v.line;
      end
      cyc = 0;
      while (!miss_ready_out && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("accept_wait", LB'(cyc), pending ? LB'(0) : LB'(cyc < 100 ? cyc : -1));
      @(negedge clk);
      if (hold) begin
         miss_valid_in     = 1'b1;
         miss_ddr_addr_in  = nxt.ddr;
         miss_line_addr_in = nxt.line;
      end else begin
         miss_valid_in = 1'b0;
      end
      check("ar_valid_lat1", LB'(ar_valid_out), LB'(1));
      unstable = 0;
      w = 0;
      forever begin
         if (!ar_valid_out || ar_addr_out !== v.ddr || ar_len_out !== 8'd3 || miss_ready_out)
            unstable++;
         if (w >= v.ar_wait) begin
            ar_ready_in = 1'b1;
            @(negedge clk);
            ar_ready_in = 1'b0;
            break;
         end
         w++;
         @(negedge clk);
      end
      check("ar_stable", LB'(unstable), LB'(0));
      check("ar_drop", LB'(ar_valid_out), LB'(0));
      k = 0;
      guard = 0;
      rbad = 0;
      tgl = 1'b1;
      while (k < NB && guard < 200) begin
         if (!r_ready_out || w_en_out || ar_valid_out || miss_ready_out || fill_done_out) rbad++;
         case (v.rmode)
            1:       r_valid_in = tgl;
            2:       r_valid_in = 1'($urandom_range(0, 1));
            default: r_valid_in = 1'b1;
         endcase
         tgl = ~tgl;
         r_data_in = v.data[k*BW +: BW];
         r_last_in = v.last_mask[k];
         if (r_valid_in && r_ready_out) k++;
         @(negedge clk);
         guard++;
      end
      check("beats_taken", LB'(k), LB'(NB));
      check("data_phase_quiet", LB'(rbad), LB'(0));
      // Offer a surplus beat during the write cycle; it must not be accepted.
      r_valid_in = 1'b1;
      r_data_in  = {4{32'hBAD0_BEEF}};
      r_last_in  = 1'b1;
      check("wen_t1", LB'(w_en_out), LB'(1));
      check("fill_done_t1", LB'(fill_done_out), LB'(1));
      check("w_addr", LB'(addr_out), LB'(v.line));
      check("w_data", w_data_out, v.data);
      check("pixel0", LB'(w_data_out[7:0]), LB'(v.data[7:0]));
      check("fill_line_addr", LB'(fill_line_addr_out), LB'(v.line));
      check("err_at_write", LB'(err_out), LB'(exp_err));
      check("no_extra_beat", LB'(r_ready_out), LB'(0));
`ifdef CACHE_FILL_BYPASS_EN
      check("bypass_valid", LB'(bypass_valid_out), LB'(1));
      check("bypass_data", bypass_data_out, v.data);
`endif
      @(negedge clk);
      r_valid_in = 1'b0;
      r_last_in  = 1'b0;
      check("wen_single", LB'({w_en_out, fill_done_out}), LB'(0));
      check("ready_t2", LB'(miss_ready_out), LB'(1));
      check("addr_hold", LB'(addr_out), LB'(v.line));
      check("err_after", LB'(err_out), LB'(exp_err));
   endtask

   initial begin
      vec_t v;
      bit   err_m;
      int   wen_seen;
      int   rdy_seen;

      tab[0] = '{32'h0000_1000, 7'd5,   mk_line(32'h0000_0000), 4'b1000, 0, 0, 1'b0};
      tab[1] = '{32'h0002_3400, 7'd17,  mk_line(32'hA5A5_0000), 4'b1000, 6, 1, 1'b0};
      tab[2] = '{32'h8000_0040, 7'd127, mk_line(32'h1234_5670), 4'b1100, 0, 0, 1'b1};
      tab[3] = '{32'hFFFF_FFC0, 7'd0,   mk_line(32'hDEAD_0000), 4'b1000, 1, 2, 1'b1};
      tab[4] = '{32'h0000_2000, 7'd33,  mk_line(32'h0000_1000), 4'b1000, 0, 0, 1'b1};
      tab[5] = '{32'h0000_3000, 7'd34,  mk_line(32'h0000_2000), 4'b1000, 0, 0, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_ready", LB'(miss_ready_out), LB'(1));
      check("rst_quiet", LB'({ar_valid_out, r_ready_out, w_en_out, fill_done_out, err_out}), LB'(0));
      check("rst_buses", LB'({ar_addr_out, ar_len_out, addr_out, fill_line_addr_out}), LB'(0));
      check("rst_wdata", w_data_out, LB'(0));

      for (int i = 0; i < 4; i++) do_fill(tab[i], 1'b0, 1'b0, tab[i], tab[i].exp_err);

      // Back-to-back: the second request is held through the whole first fill.
      do_fill(tab[4], 1'b0, 1'b1, tab[5], 1'b1);
      do_fill(tab[5], 1'b1, 1'b0, tab[5], 1'b1);

      // Reset after beat 1 has been accepted.
      @(negedge clk);
      miss_valid_in     = 1'b1;
      miss_ddr_addr_in  = 32'h0000_5000;
      miss_line_addr_in = 7'd9;
      @(negedge clk);
      miss_valid_in = 1'b0;
      ar_ready_in   = 1'b1;
      @(negedge clk);
      ar_ready_in = 1'b0;
      r_valid_in  = 1'b1;
      r_data_in   = {4{32'h5555_0000}};
      r_last_in   = 1'b0;
      @(negedge clk);
      r_data_in = {4{32'h5555_0001}};
      @(negedge clk);
      check("mid_rst_in_data", LB'(r_ready_out), LB'(1));
      rst_n     = 1'b0;
      r_data_in = {4{32'h5555_0002}};
      @(negedge clk);
      check("mid_rst_rready", LB'(r_ready_out), LB'(0));
      check("mid_rst_err_clr", LB'(err_out), LB'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", LB'(miss_ready_out), LB'(1));
      wen_seen = 0;
      rdy_seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (w_en_out || fill_done_out) wen_seen++;
         if (r_ready_out) rdy_seen++;
         @(negedge clk);
      end
      r_valid_in = 1'b0;
      check("mid_rst_no_wen", LB'(wen_seen), LB'(0));
      check("mid_rst_no_rready", LB'(rdy_seen), LB'(0));
      do_fill(tab[0], 1'b0, 1'b0, tab[0], 1'b0);

      // Random fills against the sticky-error model.
      err_m = 1'b0;
      for (int n = 0; n < 12; n++) begin
         v.ddr  = $urandom() & 32'hFFFF_FFC0;
         v.line = 7'($urandom_range(0, 127));
         for (int j = 0; j < LB / 32; j++) v.data[j*32 +: 32] = $urandom();
         v.last_mask = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b1000;
         v.ar_wait   = $urandom_range(0, 4);
         v.rmode     = $urandom_range(0, 2);
         err_m       = err_m | (v.last_mask != 4'b1000);
         v.exp_err   = err_m;
         do_fill(v, 1'b0, 1'b0, v, err_m);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
